// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter for the processor-side peripheral bus.
// Each granted transfer runs WAIT_CYC+1 access cycles; out-of-window addresses are rejected.
module pr_bus_arbiter #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [29:0] PrAddr,
  output logic [31:0] PrWD,
  output logic [3:0]  BE,
  input  logic [31:0] PrRD,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q;
  logic        win_q;   // 0 = M0, 1 = M1
  logic        last_q;
  logic        we_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [3:0]  wcnt_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        sel;
  logic [29:0] sel_addr;
  logic        in_win;

  // Sole requester wins; on a tie the master that did not go last wins.
  always_comb begin
    sel = m1_req;
    if (m0_req && m1_req) begin
      sel = ~last_q;
    end
  end

  assign sel_addr = sel ? m1_addr : m0_addr;
  assign in_win   = (sel_addr[29:2] >= 28'h7f0) && (sel_addr[29:2] <= 28'h7f2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_req || m1_req) begin
            win_q   <= sel;
            last_q  <= sel;
            we_q    <= sel ? m1_we    : m0_we;
            addr_q  <= sel_addr;
            be_q    <= sel ? m1_be    : m0_be;
            wdata_q <= sel ? m1_wdata : m0_wdata;
            if (in_win) begin
              state_q <= StAccess;
              wcnt_q  <= 4'(WAIT_CYC);
              err_q   <= 1'b0;
            end else begin
              state_q <= StDone;
              err_q   <= 1'b1;
              if (sel) rdata1_q <= 32'hffff_ffff;
              else     rdata0_q <= 32'hffff_ffff;
            end
          end
        end
        StAccess: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            if (!we_q) begin
              if (win_q) rdata1_q <= PrRD;
              else       rdata0_q <= PrRD;
            end
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic acc;
  logic fin;
  assign acc = (state_q == StAccess);
  assign fin = (state_q == StDone);

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign m0_gnt   = (acc || fin) && !win_q;
  assign m1_gnt   = (acc || fin) &&  win_q;
  assign m0_done  = fin && !win_q;
  assign m1_done  = fin &&  win_q;
  assign m0_err   = fin && !win_q && err_q;
  assign m1_err   = fin &&  win_q && err_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign PrAddr   = acc ? addr_q  : '0;
  assign PrWD     = acc ? wdata_q : '0;
  assign BE       = (acc && we_q && (wcnt_q == 4'd0)) ? be_q : '0;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed bench for pr_bus_arbiter: vector table of single transfers plus
// reset/tie and reset-abort sequences (second instance with WAIT_CYC=3).
module tb_pr_bus_arbiter;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata, PrRD;

  logic m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, busy;
  logic [31:0] m0_rdata, m1_rdata, PrWD;
  logic [29:0] PrAddr;
  logic [3:0]  BE;

  logic m0_gnt_b, m0_done_b, m0_err_b, m1_gnt_b, m1_done_b, m1_err_b, busy_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, PrWD_b;
  logic [29:0] PrAddr_b;
  logic [3:0]  BE_b;

  always #5 clk = ~clk;

  pr_bus_arbiter #(.WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .PrAddr(PrAddr), .PrWD(PrWD), .BE(BE), .PrRD(PrRD), .busy(busy)
  );

  pr_bus_arbiter #(.WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_b), .m0_done(m0_done_b), .m0_err(m0_err_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_b), .m1_done(m1_done_b), .m1_err(m1_err_b), .m1_rdata(m1_rdata_b),
    .PrAddr(PrAddr_b), .PrWD(PrWD_b), .BE(BE_b), .PrRD(PrRD), .busy(busy_b)
  );

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] byte_addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] prrd;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];
  int n_asserts = 0;
  int n_fail = 0;
  int seq [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [29:0] ea;
    int done_k = 0, acc_ok = 0, bus_cyc = 0, be_cyc = 0, be_k = 0, other_done = 0;
    logic [3:0]  be_val = '0;
    logic        err_at = 1'b0;
    logic [31:0] rd_at = '0;
    logic g, d;
    ea = v.byte_addr[31:2];
    @(negedge clk);
    PrRD = v.prrd;
    if (v.mst) begin
      m1_we = v.we; m1_addr = ea; m1_be = v.be; m1_wdata = v.wdata; m1_req = 1'b1;
    end else begin
      m0_we = v.we; m0_addr = ea; m0_be = v.be; m0_wdata = v.wdata; m0_req = 1'b1;
    end
    for (int k = 1; k <= 12 && done_k == 0; k++) begin
      @(negedge clk);
      g = v.mst ? m1_gnt : m0_gnt;
      d = v.mst ? m1_done : m0_done;
      if (PrAddr != '0 || PrWD != '0 || BE != '0) bus_cyc++;
      if (g && !d && PrAddr == ea && PrWD == v.wdata) acc_ok++;
      if (BE != '0) begin be_cyc++; be_val = BE; be_k = k; end
      if (v.mst ? m0_done : m1_done) other_done++;
      if (d) begin
        done_k = k;
        err_at = v.mst ? m1_err : m0_err;
        rd_at  = v.mst ? m1_rdata : m0_rdata;
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), 64'(done_k), v.exp_err ? 64'd1 : 64'(W + 2));
    chk($sformatf("v%0d_err", idx), 64'(err_at), 64'(v.exp_err));
    chk($sformatf("v%0d_rdata", idx), 64'(rd_at), 64'(v.exp_rdata));
    chk($sformatf("v%0d_access_cycles", idx), 64'(acc_ok), v.exp_err ? 64'd0 : 64'(W + 1));
    chk($sformatf("v%0d_bus_cycles", idx), 64'(bus_cyc), v.exp_err ? 64'd0 : 64'(W + 1));
    chk($sformatf("v%0d_be_cycles", idx), 64'(be_cyc), (v.we && !v.exp_err) ? 64'd1 : 64'd0);
    chk($sformatf("v%0d_be_value", idx), 64'(be_val), (v.we && !v.exp_err) ? 64'(v.be) : 64'd0);
    chk($sformatf("v%0d_be_cycle_pos", idx), 64'(be_k),
        (v.we && !v.exp_err) ? 64'(W + 1) : 64'd0);
    chk($sformatf("v%0d_other_done", idx), 64'(other_done), 64'd0);
  endtask

  initial begin
    int cnt, dbl, both, first_k, be_seen, done_seen;
    logic d0p, d1p, was_busy;

    vecs[0] = '{mst:1'b0, we:1'b0, byte_addr:32'h7f04, be:4'h0, wdata:32'h0,
                prrd:32'h1234, exp_err:1'b0, exp_rdata:32'h1234};
    vecs[1] = '{mst:1'b1, we:1'b1, byte_addr:32'h7f10, be:4'b0011, wdata:32'h5,
                prrd:32'h7777, exp_err:1'b0, exp_rdata:32'h0};
    vecs[2] = '{mst:1'b0, we:1'b0, byte_addr:32'h8000, be:4'h0, wdata:32'h0,
                prrd:32'h1111, exp_err:1'b1, exp_rdata:32'hffff_ffff};
    vecs[3] = '{mst:1'b1, we:1'b0, byte_addr:32'h7f2c, be:4'h0, wdata:32'h0,
                prrd:32'habcd_0123, exp_err:1'b0, exp_rdata:32'habcd_0123};
    vecs[4] = '{mst:1'b0, we:1'b1, byte_addr:32'h7f20, be:4'hf, wdata:32'hdead_beef,
                prrd:32'h5555, exp_err:1'b0, exp_rdata:32'hffff_ffff};
    vecs[5] = '{mst:1'b1, we:1'b0, byte_addr:32'h7f30, be:4'h0, wdata:32'h0,
                prrd:32'h1, exp_err:1'b1, exp_rdata:32'hffff_ffff};
    vecs[6] = '{mst:1'b0, we:1'b0, byte_addr:32'h7efc, be:4'h0, wdata:32'h0,
                prrd:32'h2, exp_err:1'b1, exp_rdata:32'hffff_ffff};
    vecs[7] = '{mst:1'b1, we:1'b1, byte_addr:32'h7f00, be:4'b1000, wdata:32'h0,
                prrd:32'h9, exp_err:1'b0, exp_rdata:32'hffff_ffff};

    // Reset held with both masters requesting in-window reads.
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h1fc0; m0_be = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h1fc4; m1_be = '0; m1_wdata = '0;
    PrRD = 32'h0;
    #12;
    chk("reset_outputs_zero", 64'(|{m0_gnt, m0_done, m0_err, m0_rdata, m1_gnt, m1_done, m1_err,
        m1_rdata, PrAddr, PrWD, BE}), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Held tie: grants must alternate starting with M0.
    seq = '{-1, -1, -1, -1};
    cnt = 0; dbl = 0; both = 0; first_k = 0; d0p = 1'b0; d1p = 1'b0;
    for (int k = 1; k <= 40 && cnt < 4; k++) begin
      @(negedge clk);
      if (m0_done && m1_done) both++;
      if ((m0_done && d0p) || (m1_done && d1p)) dbl++;
      d0p = m0_done;
      d1p = m1_done;
      if (m0_done || m1_done) begin
        if (cnt == 0) first_k = k;
        seq[cnt] = m1_done ? 1 : 0;
        cnt++;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("tie_count", 64'(cnt), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("tie_grant_%0d", i), 64'(seq[i]), 64'(i % 2));
    chk("tie_first_done_cycle", 64'(first_k), 64'(W + 2));
    chk("tie_done_one_cycle", 64'(dbl), 64'd0);
    chk("tie_no_double_done", 64'(both), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset pulse clears held read data.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rdata_cleared_m0", 64'(m0_rdata), 64'd0);
    chk("rdata_cleared_m1", 64'(m1_rdata), 64'd0);

    // WAIT_CYC=3 write aborted by reset in its 2nd access cycle.
    @(negedge clk);
    m1_we = 1'b1; m1_addr = 30'h1fc8; m1_be = 4'hf; m1_wdata = 32'h77; m1_req = 1'b1;
    be_seen = 0; done_seen = 0; was_busy = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (BE_b != '0) be_seen++;
      if (m1_done_b) done_seen++;
      if (k == 1) was_busy = busy_b;
    end
    rst = 1'b0;
    m1_req = 1'b0;
    #1;
    chk("abort_started", 64'(was_busy), 64'd1);
    chk("abort_busy_immediate", 64'(busy_b), 64'd0);
    chk("abort_outputs_immediate", 64'(|{m1_gnt_b, m1_done_b, PrAddr_b, PrWD_b, BE_b}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (BE_b != '0) be_seen++;
      if (m1_done_b || busy_b) done_seen++;
    end
    chk("abort_no_strobe", 64'(be_seen), 64'd0);
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_rdata_cleared", 64'(m1_rdata_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
